// File: rtl/imem_responder.sv
// Instruction-memory responder for the rv32imc fetch path: returns 32-bit parcels for
// halfword-aligned PCs, stitching RV32C parcels that straddle two memory words.
module imem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] reqAddr,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspInstr,
  output logic [31:0] rspAddr,
  output logic        rspErr,
  input  logic        progWe,
  input  logic [31:0] progAddr,
  input  logic [31:0] progData
);

  localparam int unsigned AW         = $clog2(MEM_WORDS);
  localparam logic [29:0] MemWords30 = 30'(MEM_WORDS);
  localparam bit          HasWait    = WAIT_CYCLES > 0;
  localparam logic [3:0]  WaitLoad   = HasWait ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {StIdle, StWait, StRead0, StRead1, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  logic [31:0] mem [MEM_WORDS];

  logic [29:0]   ridx;
  logic [AW-1:0] n;
  logic [AW:0]   n1;
  logic [31:0]   word_n, word_n1;
  logic [29:0]   pidx;
  logic          pwe;
  logic          unused_bits;

  assign ridx    = addr_q[31:2];
  assign n       = addr_q[AW+1:2];
  // One extra bit so the word after the last one is flagged instead of wrapping to 0.
  assign n1      = {1'b0, n} + {{AW{1'b0}}, 1'b1};
  assign word_n  = mem[n];
  assign word_n1 = mem[n1[AW-1:0]];

  assign pidx = progAddr[31:2];
  assign pwe  = (state_q == StIdle) && progWe && (pidx < MemWords30);

  assign unused_bits = ^{progAddr[1:0], word_n1[31:16]};

  always_ff @(posedge clk) begin
    if (pwe) begin
      mem[pidx[AW-1:0]] <= progData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      lo_q    <= '0;
      instr_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    instr_d  = instr_q;
    addr_d   = addr_q;
    err_d    = err_q;
    reqReady = 1'b0;

    case (state_q)
      StIdle: begin
        // Program load wins over fetch so preloads never race a request.
        reqReady = ~progWe & ~rst;
        if (reqValid && reqReady) begin
          addr_d  = reqAddr;
          cnt_d   = WaitLoad;
          state_d = HasWait ? StWait : StRead0;
        end
      end

      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StRead0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      StRead0: begin
        if (addr_q[0] || (ridx >= MemWords30)) begin
          instr_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else if (!addr_q[1]) begin
          instr_d = word_n;
          state_d = StResp;
        end else if (word_n[17:16] != 2'b11) begin
          instr_d = {16'h0000, word_n[31:16]};
          state_d = StResp;
        end else begin
          lo_d    = word_n[31:16];
          state_d = StRead1;
        end
      end

      StRead1: begin
        if (n1[AW]) begin
          instr_d = '0;
          err_d   = 1'b1;
        end else begin
          instr_d = {word_n1[15:0], lo_q};
        end
        state_d = StResp;
      end

      StResp: begin
        if (rspReady) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign rspValid = (state_q == StResp);
  assign rspInstr = instr_q;
  assign rspAddr  = addr_q;
  assign rspErr   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: latency, RV32C alignment, errors, back-pressure, reset.
module tb_imem_responder;

  localparam int unsigned Words = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_instr, rsp_addr;
  logic        rsp_err;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0, prog_data = '0;

  logic        req_valid_w = 1'b0, req_ready_w;
  logic [31:0] req_addr_w = '0;
  logic        rsp_valid_w, rsp_ready_w = 1'b1;
  logic [31:0] rsp_instr_w, rsp_addr_w;
  logic        rsp_err_w;
  logic        prog_we_w = 1'b0;
  logic [31:0] prog_addr_w = '0, prog_data_w = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_responder #(.MEM_WORDS(Words), .WAIT_CYCLES(0)) dut (
    .clk(clk), .rst(rst),
    .reqValid(req_valid), .reqReady(req_ready), .reqAddr(req_addr),
    .rspValid(rsp_valid), .rspReady(rsp_ready), .rspInstr(rsp_instr),
    .rspAddr(rsp_addr), .rspErr(rsp_err),
    .progWe(prog_we), .progAddr(prog_addr), .progData(prog_data)
  );

  imem_responder #(.MEM_WORDS(Words), .WAIT_CYCLES(3)) dut_w (
    .clk(clk), .rst(rst),
    .reqValid(req_valid_w), .reqReady(req_ready_w), .reqAddr(req_addr_w),
    .rspValid(rsp_valid_w), .rspReady(rsp_ready_w), .rspInstr(rsp_instr_w),
    .rspAddr(rsp_addr_w), .rspErr(rsp_err_w),
    .progWe(prog_we_w), .progAddr(prog_addr_w), .progData(prog_data_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Returns at the negedge of cycle t+1, t being the acceptance cycle.
  task automatic send(input logic [31:0] a);
    int k = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a;
    #1;
    while (!req_ready && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (!req_ready) check("accept timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // lat counts cycles from acceptance to the first cycle with rsp_valid high.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk); lat++;
    end
    if (!rsp_valid) check("response timeout", 32'd0, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a, output int lat);
    send(a);
    wait_rsp(lat);
  endtask

  // Let the handshake edge pass with rsp_ready high.
  task automatic drain();
    rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [31:0] held_instr, held_addr;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_instr", rsp_instr, 32'h0);
    check("rst rsp_addr", rsp_addr, 32'h0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst req_ready", 32'(req_ready), 32'd1);

    // Aligned fetch
    prog(32'h4, 32'h00A0_0093);
    fetch(32'h4, lat);
    check("aligned lat", 32'(lat), 32'd2);
    check("aligned instr", rsp_instr, 32'h00A0_0093);
    check("aligned addr", rsp_addr, 32'h4);
    check("aligned err", 32'(rsp_err), 32'd0);
    drain();
    check("ready after handshake", 32'(req_ready), 32'd1);
    check("valid after handshake", 32'(rsp_valid), 32'd0);

    // WAIT_CYCLES=3 instance
    @(negedge clk);
    prog_we_w = 1'b1; prog_addr_w = 32'h4; prog_data_w = 32'h00A0_0093;
    @(negedge clk);
    prog_we_w = 1'b0; req_valid_w = 1'b1; req_addr_w = 32'h4;
    #1;
    check("wait req_ready", 32'(req_ready_w), 32'd1);
    @(negedge clk);
    req_valid_w = 1'b0;
    lat = 1;
    while (!rsp_valid_w && lat < 40) begin
      @(negedge clk); lat++;
    end
    check("wait lat", 32'(lat), 32'd5);
    check("wait instr", rsp_instr_w, 32'h00A0_0093);
    check("wait addr", rsp_addr_w, 32'h4);
    check("wait err", 32'(rsp_err_w), 32'd0);

    // Spanning 32-bit parcel
    prog(32'h0, 32'h0093_4501);
    prog(32'h4, 32'h1234_00A0);
    fetch(32'h2, lat);
    check("span lat", 32'(lat), 32'd3);
    check("span instr", rsp_instr, 32'h00A0_0093);
    check("span addr", rsp_addr, 32'h2);
    drain();

    // Compressed parcel in upper half
    prog(32'h0, 32'h4505_0000);
    fetch(32'h2, lat);
    check("rvc lat", 32'(lat), 32'd2);
    check("rvc instr", rsp_instr, 32'h0000_4505);
    check("rvc err", 32'(rsp_err), 32'd0);
    drain();

    // Errors
    fetch(32'h3, lat);
    check("odd lat", 32'(lat), 32'd2);
    check("odd err", 32'(rsp_err), 32'd1);
    check("odd instr", rsp_instr, 32'h0);
    drain();
    check("err cleared", 32'(rsp_err), 32'd0);
    fetch(32'(4 * Words), lat);
    check("oor lat", 32'(lat), 32'd2);
    check("oor err", 32'(rsp_err), 32'd1);
    drain();
    prog(32'(4 * (Words - 1)), 32'h0013_0000);
    fetch(32'(4 * (Words - 1) + 2), lat);
    check("edge span lat", 32'(lat), 32'd3);
    check("edge span err", 32'(rsp_err), 32'd1);
    check("edge span instr", rsp_instr, 32'h0);
    check("edge span addr", rsp_addr, 32'(4 * (Words - 1) + 2));
    drain();

    // Out-of-range program write must not alias onto word 1
    prog(32'(4 * (Words + 1)), 32'hDEAD_BEEF);
    fetch(32'h4, lat);
    check("dropped write", rsp_instr, 32'h1234_00A0);
    drain();

    // Back-pressure
    rsp_ready = 1'b0;
    fetch(32'h4, lat);
    held_instr = rsp_instr;
    held_addr  = rsp_addr;
    check("bp instr", held_instr, 32'h1234_00A0);
    repeat (5) begin
      @(negedge clk);
      check("bp valid", 32'(rsp_valid), 32'd1);
      check("bp hold instr", rsp_instr, 32'h1234_00A0);
      check("bp hold addr", rsp_addr, 32'h4);
      check("bp req_ready", 32'(req_ready), 32'd0);
    end
    drain();
    check("bp released", 32'(rsp_valid), 32'd0);
    check("bp instr kept", rsp_instr, held_instr);
    check("bp addr kept", rsp_addr, held_addr);

    // Program write and request together: write first, request after
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'hCAFE_0013;
    req_valid = 1'b1; req_addr = 32'h8;
    #1;
    check("prog blocks req", 32'(req_ready), 32'd0);
    @(negedge clk);
    prog_we = 1'b0;
    #1;
    check("req after prog", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("simul lat", 32'(lat), 32'd2);
    check("simul instr", rsp_instr, 32'hCAFE_0013);
    drain();

    // Reset while in READ1
    prog(32'hC, 32'h0093_0000);
    prog(32'h10, 32'h0000_00A0);
    send(32'hE);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid-rst idle", 32'(req_ready), 32'd1);
    check("mid-rst instr", rsp_instr, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("mid-rst no rsp", 32'(rsp_valid), 32'd0);
    end
    fetch(32'h4, lat);
    check("post-rst lat", 32'(lat), 32'd2);
    check("post-rst instr", rsp_instr, 32'h1234_00A0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder on the fetch side of the rv32imc core; it is the other end of the controller's program-counter fetch request.
- Accepts a halfword-aligned fetch address over a valid/ready request channel and returns the 32-bit instruction parcel over a valid/ready response channel.
- Handles RV32C halfword alignment, including parcels that span two memory words.
- Includes a program-load write port for boot and bench preloading.

Parameters:
MEM_WORDS, 1024, depth of the instruction memory in 32-bit words (power of two, at least 2)
WAIT_CYCLES, 0, extra stall cycles inserted after request acceptance, before the first memory read (0..15)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
reqValid  in  1  fetch request valid
reqReady  out  1  responder can accept a request
reqAddr  in  32  fetch byte address (the PC)
rspValid  out  1  response valid
rspReady  in  1  consumer accepts the response
rspInstr  out  32  instruction parcel
rspAddr  out  32  address of the request being answered
rspErr  out  1  misaligned or out-of-range fetch
progWe  in  1  program-load write enable
progAddr  in  32  program-load byte address (word index = progAddr[31:2])
progData  in  32  program-load word

Behaviour:
- Reset, sampled on the clock edge while rst=1:
  - state goes to IDLE; reqReady=0 while rst=1; rspValid=0, rspInstr=0, rspAddr=0, rspErr=0.
  - Memory contents are not cleared.
  - Reset during any state aborts the transaction; no response is produced.
- FSM states: IDLE, WAIT, READ0, READ1, RESP.
- IDLE:
  - reqReady = ~progWe (program load takes priority).
  - When progWe=1: mem[progAddr[31:2]] <= progData. Writes with an index >= MEM_WORDS are dropped.
  - progWe is ignored in all states other than IDLE.
  - On reqValid&reqReady: latch reqAddr into rspAddr. Next state is WAIT if WAIT_CYCLES>0, otherwise READ0.
- WAIT: a down-counter loaded with WAIT_CYCLES-1; go to READ0 when the counter reaches 0.
- Error check, evaluated on the latched address at entry to READ0:
  - An error exists if addr[0]=1, or word index N=addr[31:2] >= MEM_WORDS.
  - On error: skip the memory read, rspInstr=0, rspErr=1, go to RESP.
- READ0 (registered read of word N):
  - addr[1]=0: rspInstr = word N; go to RESP.
  - addr[1]=1, low half = word N[31:16]:
    - If low half[1:0] != 2'b11 (compressed): rspInstr = {16'h0, low half}; go to RESP.
    - Otherwise hold the low half and go to READ1.
- READ1:
  - If N+1 >= MEM_WORDS: rspInstr=0, rspErr=1.
  - Otherwise rspInstr = {word(N+1)[15:0], held low half}.
  - Go to RESP. N+1 is computed at index width plus one bit, so there is no wrap-around to word 0.
- RESP:
  - rspValid=1. rspInstr, rspAddr and rspErr are held stable until rspReady=1.
  - On the handshake edge: rspValid <= 0, rspErr <= 0, go to IDLE. rspInstr and rspAddr keep their last values.
- reqReady is 0 in every state except IDLE; one transaction is outstanding at a time.
- Latency, with request accepted in cycle t and W = WAIT_CYCLES:
  - Single-word fetch or error: rspValid first high in cycle t+2+W.
  - Spanning fetch: rspValid first high in cycle t+3+W.
  - The next request can be accepted in the cycle after the response handshake.
- Back-pressure: rspReady=0 holds RESP indefinitely with no change on any output.

Test Plan:
- Reset then idle: assert rst for 2 cycles, release -> rspValid=0, rspInstr=0, rspErr=0; reqReady=1 in the first cycle after release.
- Aligned fetch: preload mem[1]=32'h00A00093, request 32'h4 in cycle t, rspReady=1 -> rspValid in t+2, rspInstr=32'h00A00093, rspAddr=32'h4, rspErr=0; with WAIT_CYCLES=3 the response arrives in t+5.
- Spanning fetch: mem[0]=32'h0093_4501, mem[1]=32'h1234_00A0, request 32'h2 -> low half 16'h0093 is 32-bit, so response in t+3 with rspInstr=32'h00A0_0093. Then set mem[0]=32'h4505_0000, request 32'h2 -> compressed, response in t+2 with rspInstr=32'h0000_4505.
- Errors: request 32'h3 -> rspErr=1, rspInstr=0, response in t+2. Request 4*MEM_WORDS -> rspErr=1. Request 4*(MEM_WORDS-1)+2 holding a 32-bit low half -> rspErr=1, response in t+3.
- Back-pressure and simultaneity: hold rspReady=0 for 5 cycles -> outputs stable and reqReady=0. In IDLE, drive progWe=1 and reqValid=1 together -> write lands, request not accepted until progWe drops.
- Reset mid-operation: assert rst in READ1 -> no response is emitted, state returns to IDLE, and the next fetch of 32'h4 returns the correct word.
